// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width, reset vector and the address type
// used by the program counter and the next-PC logic.
package rv32i_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] addr_t;

   // Address the core starts fetching from after reset.
   localparam addr_t RESET_VECTOR = 32'h0000_0000;

endpackage : rv32i_pkg

// File: rtl/pc_module_if.sv
// Program-counter bus: the next-PC mux drives PC_Next, the PC register drives PC.
interface pc_module_if;
   import rv32i_pkg::*;

   addr_t PC_Next;
   addr_t PC;

   // Next-PC logic side: supplies the next address, observes the current PC.
   modport master (
      output PC_Next,
      input  PC
   );

   // PC register side: consumes the next address, publishes the current PC.
   modport slave (
      input  PC_Next,
      output PC
   );

endinterface : pc_module_if

// File: rtl/pc_module.sv
// Program-counter register for the RV32I single-cycle core. Loads PC_Next on
// every rising clock edge; asynchronous active-high reset forces RESET_VECTOR.
// Values are stored unmodified: alignment is checked by fetch/exception logic.
module pc_module
   import rv32i_pkg::*;
#(
   parameter int    XLEN_P         = XLEN,
   parameter addr_t RESET_VECTOR_P = RESET_VECTOR
) (
   input  logic        clk,
   input  logic        rst,
   pc_module_if.slave  bus
);

   addr_t pc_q;
   addr_t pc_d;

   // Elaboration-time parameter checks: the datapath is fixed at 32 bits and
   // the reset vector must be word aligned.
   if (XLEN_P != 32) begin : g_bad_xlen
      $error("pc_module: XLEN must be 32");
   end
   if (RESET_VECTOR_P[1:0] != 2'b00) begin : g_bad_reset_vector
      $error("pc_module: RESET_VECTOR must be word aligned");
   end

   // No enable: stalls are handled upstream by feeding PC back on PC_Next.
   always_comb begin
      pc_d = bus.PC_Next;
   end

   // PC register with asynchronous reset to the reset vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_VECTOR_P;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign bus.PC = pc_q;

endmodule : pc_module

// File: tb/tb_pc_module.sv
// Self-checking bench for pc_module: directed steps followed by randomized
// traffic checked against a behavioural reference of the PC register.
module tb_pc_module;
   import rv32i_pkg::*;

   logic clk;
   logic rst;
   pc_module_if bus ();

   int n_assert;
   int n_fail;
   addr_t exp_pc;

   pc_module dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare the current PC with the expected value.
   task automatic check(input string tag, input addr_t expected);
      n_assert++;
      assert (bus.PC === expected)
      else begin
         n_fail++;
         $error("FAIL %s: PC=%h expected %h", tag, bus.PC, expected);
      end
   endtask

   // Advance past one rising edge and settle 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference behaviour: a register that captures PC_Next on each edge
   // unless reset is held, in which case it sits at the reset vector.
   task automatic edge_model();
      if (rst) exp_pc = RESET_VECTOR;
      else     exp_pc = bus.PC_Next;
      step();
   endtask

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      n_assert    = 0;
      n_fail      = 0;
      exp_pc      = RESET_VECTOR;
      rst         = 1'b0;
      bus.PC_Next = 32'hA5A5_A5A5;

      // 1: asynchronous reset before any clock edge, then held across edges.
      #2 rst = 1'b1;
      #1 check("reset_async", 32'h0000_0000);
      step();
      check("reset_hold_edge1", 32'h0000_0000);
      step();
      check("reset_hold_edge2", 32'h0000_0000);

      // 2: release reset between edges, PC must not move until the edge.
      #2 rst = 1'b0;
      bus.PC_Next = 32'hDEAD_BEEF;
      #1 check("release_no_edge", 32'h0000_0000);
      step();
      check("first_load", 32'hDEAD_BEEF);

      // PC_Next changes between edges have no effect until the next edge.
      bus.PC_Next = 32'h1234_5678;
      #2 check("between_edges", 32'hDEAD_BEEF);

      // 3: one-edge latency.
      step();
      check("load_12345678", 32'h1234_5678);

      // 4: reset mid-cycle overrides at once and holds across edges.
      #2 rst = 1'b1;
      #1 check("midcycle_reset", 32'h0000_0000);
      step();
      check("reset_hold_a", 32'h0000_0000);
      step();
      check("reset_hold_b", 32'h0000_0000);

      // 5: release and load.
      #2 rst = 1'b0;
      bus.PC_Next = 32'h1111_1111;
      step();
      check("reload_11111111", 32'h1111_1111);

      // 6: misaligned value stored unmodified.
      bus.PC_Next = 32'h0000_0003;
      step();
      check("misaligned", 32'h0000_0003);
      exp_pc = 32'h0000_0003;

      // Randomized traffic with occasional mid-cycle resets.
      for (int i = 0; i < 300; i++) begin
         bus.PC_Next = $urandom;
         if ($urandom_range(0, 15) == 0) begin
            #1 rst = 1'b1;
            exp_pc = RESET_VECTOR;
            #1 check("rand_async_reset", exp_pc);
         end else if (rst && $urandom_range(0, 1) == 1) begin
            #1 rst = 1'b0;
         end
         #1 check("rand_between", exp_pc);
         edge_model();
         check("rand_edge", exp_pc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_pc_module
